spi_ad9268_slave: RTL and testbench
===================================

Name: spi_ad9268_slave

Overview:
- Responder end of the 3-wire AD9268-style SPI link: 24-bit frames of R/W, W[1:0], A[12:0], then data, MSB first.
- Oversamples sclk/csb/sdio on the local clk, decodes frames, and commits writes to an internal 8-bit register file.
- Drives read data back on the shared sdio line.
- Used as the bench/emulation counterpart of the SPI master, and as the slave port of FPGA-side ADC-control emulation.

Parameters:
- AW, 9: register file address width; 2^AW bytes implemented.
- SYNC, 2: synchronizer depth for sclk, csb and sdio_i.

Ports:
- clk  input  1  local clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sclk  input  1  SPI serial clock from master (asynchronous to clk).
- csb  input  1  SPI chip select, active low.
- sdio_i  input  1  sdio pad input.
- sdio_o  output  1  sdio pad output data.
- sdio_oe  output  1  sdio pad output enable; top level builds the inout.
- lcl_we  input  1  local write strobe into the register file.
- lcl_addr  input  AW  local write address.
- lcl_din  input  8  local write data.
- wr_stb  output  1  one-cycle pulse per SPI-written byte.
- wr_addr  output  AW  address of the byte committed at wr_stb.
- wr_data  output  8  data of the byte committed at wr_stb.
- busy  output  1  high while a frame is in progress (synchronized csb low).
- frame_done  output  1  one-cycle pulse when csb rises after a complete frame.
- frame_err  output  1  one-cycle pulse when csb rises after an incomplete or over-clocked frame.

Behaviour:
- Reset (async, rst_n=0):
  - sdio_oe=0, sdio_o=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0.
  - FSM returns to IDLE and the bit counter clears.
  - Register file contents are not reset.
- Input conditioning:
  - sclk, csb and sdio_i pass through SYNC flops.
  - Edge detect is done on the synchronized sclk.
  - sclk high and low phases must each be >= SYNC+2 clk cycles.
- Sampling: sdio is sampled on each synchronized sclk rising edge while csb is low. Master drives on sclk low, slave samples on rise.
- FSM IDLE:
  - csb falling -> HDR; clear bit count, busy=1.
- FSM HDR:
  - Shift in 16 bits: rw=bit23, w=bits22:21, a=bits20:8.
  - nbytes = w+1 (1 to 4).
  - On the 16th rise: rw=0 -> WDATA, rw=1 -> RDATA.
- FSM WDATA:
  - Shift 8 bits per byte.
  - On each byte's 8th rise, if a < 2^AW: write regfile[a], pulse wr_stb with wr_addr=a[AW-1:0], wr_data=byte.
  - If a >= 2^AW, the byte is dropped and wr_stb stays 0.
  - Then a = a-1, wrapping at 13 bits.
  - After nbytes bytes -> HOLD.
- FSM RDATA:
  - Within 2 clk of the 16th rise detection: sdio_oe=1, load shifter with regfile[a] (0x00 if a >= 2^AW), sdio_o=bit7.
  - On each synchronized sclk fall, shift the next bit out.
  - After each byte's 8th rise: a = a-1 and reload on the following fall.
  - After nbytes bytes -> HOLD with sdio_oe=0.
- FSM HOLD:
  - Ignore data.
  - Any further sclk rise sets a sticky overrun flag.
- csb rising (synchronized), from any non-IDLE state:
  - Abort immediately and set sdio_oe=0.
  - Pulse frame_done if in HOLD with no overrun; otherwise pulse frame_err.
  - busy=0, return to IDLE.
- Aborted frames:
  - Bytes already committed stay written.
  - A partial byte is discarded with no wr_stb.
- Register file write precedence: an SPI byte commit and lcl_we in the same cycle to the same address -> SPI data wins. Different addresses -> both are written.
- sdio_oe never asserts while csb is high or during HDR/WDATA.
- sclk edges while csb is high are ignored.

Test Plan:
- SPI write frame 0x0005A5 -> one wr_stb with wr_addr=0x005, wr_data=0xA5; frame_done pulse; frame_err=0.
- After that, read frame 0x8005xx -> sdio_oe rises after the 16th sclk rise; master samples 1,0,1,0,0,1,0,1; sdio_oe=0 after csb rises; frame_done pulse.
- W=01 write at a=0x010 with bytes 0x11,0x22 -> wr_stb at 0x010=0x11, then 0x00F=0x22; a 2-byte read at 0x010 returns 0x11,0x22.
- csb raised after 12 sclk rises -> no wr_stb, frame_err pulse, busy=0. A following full write frame succeeds.
- Write to a=0x0200 (AW=9) -> no wr_stb, frame_done. Read of 0x0200 returns 0x00. lcl_we to 0x005 in the same clk as an SPI commit to 0x005 -> SPI value is read back.
- rst_n low during the RDATA byte -> sdio_oe=0 with no clk edge. After release and a new csb cycle, a normal read succeeds. 25th sclk rise in a 1-byte frame -> frame_err.

Source files
------------

// File: rtl/spi_ad9268_slave.sv
// Responder end of a 3-wire AD9268-style SPI link with an 8-bit register file.
// Ports: clk/rst_n; sclk, csb, sdio_i (async pads), sdio_o/sdio_oe (tristate);
//   lcl_we/lcl_addr/lcl_din local write; wr_stb/wr_addr/wr_data SPI commit;
//   busy, frame_done, frame_err status.
module spi_ad9268_slave #(
    parameter int AW   = 9,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sclk,
    input  logic          csb,
    input  logic          sdio_i,
    output logic          sdio_o,
    output logic          sdio_oe,
    input  logic          lcl_we,
    input  logic [AW-1:0] lcl_addr,
    input  logic [7:0]    lcl_din,
    output logic          wr_stb,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy,
    output logic          frame_done,
    output logic          frame_err
);
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        HOLD
    } state_e;

    logic [SYNC-1:0] sclk_sync_q;
    logic [SYNC-1:0] csb_sync_q;
    logic [SYNC-1:0] sdio_sync_q;
    logic            sclk_prev_q;
    logic            csb_prev_q;

    logic sclk_s, csb_s, sdio_s;
    logic sclk_rise, sclk_fall;
    logic csb_fall, csb_rise;

    // csb synchronizer resets high so reset release never looks like a select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            sdio_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], sclk};
            csb_sync_q  <= {csb_sync_q[SYNC-2:0], csb};
            sdio_sync_q <= {sdio_sync_q[SYNC-2:0], sdio_i};
            sclk_prev_q <= sclk_s;
            csb_prev_q  <= csb_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC-1];
    assign csb_s     = csb_sync_q[SYNC-1];
    assign sdio_s    = sdio_sync_q[SYNC-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csb_fall  = csb_prev_q & ~csb_s;
    assign csb_rise  = ~csb_prev_q & csb_s;

    state_e        state_q;
    logic [3:0]    bit_q;
    logic [14:0]   shift_q;
    logic [12:0]   addr_q;
    logic [2:0]    bytes_q;
    logic [6:0]    tx_q;
    logic          reload_q;
    logic          ovr_q;
    logic          sdio_o_q;
    logic          sdio_oe_q;
    logic          wr_stb_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [7:0] mem [2**AW];

    // Shift register with the current bit appended: full header on the
    // 16th rise, full data byte in [7:0] on each 8th data rise.
    logic [15:0] hdr_w;
    logic [7:0]  hdr_rd;
    logic [7:0]  addr_rd;

    assign hdr_w = {shift_q, sdio_s};

    // Addresses beyond the implemented file read back as zero
    always_comb begin
        hdr_rd  = 8'h00;
        addr_rd = 8'h00;
        if (hdr_w[12:AW] == '0) hdr_rd = mem[hdr_w[AW-1:0]];
        if (addr_q[12:AW] == '0) addr_rd = mem[addr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            bytes_q   <= '0;
            tx_q      <= '0;
            reload_q  <= 1'b0;
            ovr_q     <= 1'b0;
            sdio_o_q  <= 1'b0;
            sdio_oe_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_stb_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (state_q != IDLE && csb_rise) begin
                state_q   <= IDLE;
                bit_q     <= '0;
                reload_q  <= 1'b0;
                sdio_oe_q <= 1'b0;
                sdio_o_q  <= 1'b0;
                busy_q    <= 1'b0;
                if (state_q == HOLD && !ovr_q) done_q <= 1'b1;
                else err_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (csb_fall) begin
                            state_q <= HDR;
                            bit_q   <= '0;
                            ovr_q   <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                    HDR: begin
                        if (sclk_rise) begin
                            shift_q <= hdr_w[14:0];
                            bit_q   <= bit_q + 4'd1;
                            if (bit_q == 4'd15) begin
                                bit_q   <= '0;
                                addr_q  <= hdr_w[12:0];
                                bytes_q <= {1'b0, hdr_w[14:13]} + 3'd1;
                                if (hdr_w[15]) begin
                                    state_q   <= RDATA;
                                    sdio_oe_q <= 1'b1;
                                    tx_q      <= hdr_rd[6:0];
                                    sdio_o_q  <= hdr_rd[7];
                                end else begin
                                    state_q <= WDATA;
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shift_q <= hdr_w[14:0];
                            bit_q   <= bit_q + 4'd1;
                            if (bit_q == 4'd7) begin
                                bit_q <= '0;
                                if (addr_q[12:AW] == '0) begin
                                    wr_stb_q  <= 1'b1;
                                    wr_addr_q <= addr_q[AW-1:0];
                                    wr_data_q <= hdr_w[7:0];
                                end
                                addr_q  <= addr_q - 13'd1;
                                bytes_q <= bytes_q - 3'd1;
                                if (bytes_q == 3'd1) state_q <= HOLD;
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_rise) begin
                            bit_q <= bit_q + 4'd1;
                            if (bit_q == 4'd7) begin
                                bit_q   <= '0;
                                addr_q  <= addr_q - 13'd1;
                                bytes_q <= bytes_q - 3'd1;
                                if (bytes_q == 3'd1) begin
                                    state_q   <= HOLD;
                                    sdio_oe_q <= 1'b0;
                                    sdio_o_q  <= 1'b0;
                                end else begin
                                    reload_q <= 1'b1;
                                end
                            end
                        end else if (sclk_fall) begin
                            // bit7 of the first byte is already out, so the
                            // fall right after the header shifts nothing
                            if (reload_q) begin
                                reload_q <= 1'b0;
                                tx_q     <= addr_rd[6:0];
                                sdio_o_q <= addr_rd[7];
                            end else if (bit_q != 4'd0) begin
                                tx_q     <= {tx_q[5:0], 1'b0};
                                sdio_o_q <= tx_q[6];
                            end
                        end
                    end
                    HOLD: begin
                        if (sclk_rise) ovr_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // SPI commit is issued last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (lcl_we) mem[lcl_addr] <= lcl_din;
        if (wr_stb_q) mem[wr_addr_q] <= wr_data_q;
    end

    assign sdio_o     = sdio_o_q;
    assign sdio_oe    = sdio_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_spi_ad9268_slave.sv
// Randomized bench for spi_ad9268_slave against a byte-array register model.
// Drives SPI frames as a master and checks commits, read data and status.
module tb_spi_ad9268_slave;
    localparam int AW = 9;
    localparam int LO = 6;
    localparam int HI = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sclk, csb, sdio_i;
    logic          sdio_o, sdio_oe;
    logic          lcl_we;
    logic [AW-1:0] lcl_addr;
    logic [7:0]    lcl_din;
    logic          wr_stb;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy, frame_done, frame_err;

    spi_ad9268_slave #(.AW(AW), .SYNC(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .csb(csb),
        .sdio_i(sdio_i), .sdio_o(sdio_o), .sdio_oe(sdio_oe),
        .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_din(lcl_din),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    logic [7:0]  ref_mem [512];
    logic [16:0] wq[$];
    logic        rxq[$];
    int          ndone = 0;
    int          nerr  = 0;
    logic        oe_hdr_bad;
    logic        busy_seen;
    logic        abort_req = 1'b0;
    logic        coll_en = 1'b0;
    logic        coll_hit;
    logic [8:0]  coll_addr;
    logic [7:0]  coll_din;

    always @(negedge clk) begin
        if (wr_stb) wq.push_back({wr_addr, wr_data});
        if (frame_done) ndone++;
        if (frame_err) nerr++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mrd(input logic [12:0] a);
        return (a < 13'd512) ? ref_mem[a[8:0]] : 8'h00;
    endfunction

    task automatic spi_xfer(input logic [63:0] d, input int nb);
        rxq.delete();
        oe_hdr_bad = 1'b0;
        busy_seen  = 1'b0;
        csb = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nb; i++) begin
            if (abort_req) break;
            sclk   = 1'b0;
            sdio_i = d[63-i];
            repeat (LO) @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (i < 16 && sdio_oe) oe_hdr_bad = 1'b1;
            if (sdio_oe) rxq.push_back(sdio_o);
            sclk = 1'b1;
            repeat (HI) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (LO) @(negedge clk);
        csb = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_write(input logic [12:0] a, input logic [1:0] w,
                            input logic [31:0] bytes, input string tag);
        int n;
        int wb, db, eb;
        logic [12:0] ad;
        logic [7:0]  b;
        logic [16:0] exp_q[$];
        n  = int'(w) + 1;
        wb = wq.size();
        db = ndone;
        eb = nerr;
        coll_hit = 1'b0;
        fork
            spi_xfer({1'b0, w, a, bytes, 16'h0}, 16 + 8 * n);
            begin
                if (coll_en) begin
                    for (int k = 0; k < 2000; k++) begin
                        @(negedge clk);
                        if (wr_stb) begin
                            lcl_we   = 1'b1;
                            lcl_addr = coll_addr;
                            lcl_din  = coll_din;
                            @(negedge clk);
                            lcl_we   = 1'b0;
                            coll_hit = 1'b1;
                            break;
                        end
                    end
                end
            end
        join
        if (coll_en) begin
            chk({tag, ":coll"}, coll_hit, 1'b1);
            if (coll_hit) ref_mem[coll_addr] = coll_din;
        end
        ad = a;
        for (int k = 0; k < n; k++) begin
            b = bytes[31-8*k -: 8];
            if (ad < 13'd512) begin
                exp_q.push_back({ad[8:0], b});
                ref_mem[ad[8:0]] = b;
            end
            ad = ad - 13'd1;
        end
        chk({tag, ":nwr"}, wq.size() - wb, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (wb + k < wq.size())
                chk({tag, ":wr"}, wq[wb+k], exp_q[k]);
        chk({tag, ":busy_in"}, busy_seen, 1'b1);
        chk({tag, ":done"}, ndone - db, 1);
        chk({tag, ":err"}, nerr - eb, 0);
        chk({tag, ":busy"}, busy, 1'b0);
    endtask

    task automatic do_read(input logic [12:0] a, input logic [1:0] w,
                           input string tag);
        int n;
        int wb, db, eb;
        logic [12:0] ad;
        logic [7:0]  got;
        n  = int'(w) + 1;
        wb = wq.size();
        db = ndone;
        eb = nerr;
        spi_xfer({1'b1, w, a, 48'h0}, 16 + 8 * n);
        chk({tag, ":hdr_oe"}, oe_hdr_bad, 1'b0);
        chk({tag, ":nbits"}, rxq.size(), 8 * n);
        ad = a;
        for (int k = 0; k < n; k++) begin
            if (rxq.size() >= 8 * (k + 1)) begin
                for (int j = 0; j < 8; j++) got[7-j] = rxq[8*k+j];
                chk({tag, ":byte"}, got, mrd(ad));
            end
            ad = ad - 13'd1;
        end
        chk({tag, ":oe_off"}, sdio_oe, 1'b0);
        chk({tag, ":done"}, ndone - db, 1);
        chk({tag, ":err"}, nerr - eb, 0);
        chk({tag, ":nwr"}, wq.size() - wb, 0);
    endtask

    initial begin
        int wb, db, eb;
        logic [12:0] ra;
        rst_n = 1'b0;
        sclk = 1'b0; csb = 1'b1; sdio_i = 1'b0;
        lcl_we = 1'b0; lcl_addr = '0; lcl_din = '0;
        repeat (3) @(negedge clk);
        chk("rst_oe", sdio_oe, 1'b0);
        chk("rst_o", sdio_o, 1'b0);
        chk("rst_stb", wr_stb, 1'b0);
        chk("rst_waddr", wr_addr, 9'h0);
        chk("rst_wdata", wr_data, 8'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 512; i++) begin
            lcl_we   = 1'b1;
            lcl_addr = 9'(i);
            lcl_din  = 8'($urandom);
            ref_mem[i] = lcl_din;
            @(negedge clk);
        end
        lcl_we = 1'b0;
        repeat (4) @(negedge clk);

        do_write(13'h005, 2'd0, 32'hA5000000, "wr005");
        do_read(13'h005, 2'd0, "rd005");
        chk("rd005_val", mrd(13'h005), 8'hA5);
        do_write(13'h010, 2'd1, 32'h11220000, "wr010");
        do_read(13'h010, 2'd1, "rd010");

        // frame aborted after 12 header rises
        wb = wq.size(); db = ndone; eb = nerr;
        spi_xfer({1'b0, 2'b00, 13'h006, 48'h77}, 12);
        chk("abort:nwr", wq.size() - wb, 0);
        chk("abort:err", nerr - eb, 1);
        chk("abort:done", ndone - db, 0);
        chk("abort:busy", busy, 1'b0);
        do_write(13'h006, 2'd0, 32'hC3000000, "wr_after_abort");

        do_write(13'h200, 2'd0, 32'h99000000, "wr200");
        do_read(13'h200, 2'd0, "rd200");

        // local write colliding with an SPI commit
        coll_en = 1'b1;
        coll_addr = 9'h005; coll_din = 8'h3C;
        do_write(13'h005, 2'd0, 32'h5E000000, "coll_same");
        coll_addr = 9'h006; coll_din = 8'h4D;
        do_write(13'h007, 2'd0, 32'h6F000000, "coll_diff");
        coll_en = 1'b0;
        do_read(13'h007, 2'd1, "rd_coll");
        do_read(13'h005, 2'd0, "rd_coll5");

        // async reset in the middle of a read byte
        fork
            spi_xfer({1'b1, 2'b00, 13'h005, 48'h0}, 24);
            begin
                for (int k = 0; k < 3000 && !sdio_oe; k++) @(negedge clk);
                chk("rstrd:oe_before", sdio_oe, 1'b1);
                repeat (20) @(negedge clk);
                #2;
                rst_n = 1'b0;
                abort_req = 1'b1;
                #1;
                chk("rstrd:oe_async", sdio_oe, 1'b0);
                repeat (20) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        abort_req = 1'b0;
        repeat (8) @(negedge clk);
        do_read(13'h005, 2'd0, "rd_after_rst");

        // one rise too many in a one-byte write
        wb = wq.size(); db = ndone; eb = nerr;
        spi_xfer({1'b0, 2'b00, 13'h003, 8'h5A, 40'hFF_FFFF_FFFF}, 25);
        ref_mem[3] = 8'h5A;
        chk("ovr:nwr", wq.size() - wb, 1);
        if (wq.size() > wb) chk("ovr:wr", wq[wb], {9'h003, 8'h5A});
        chk("ovr:err", nerr - eb, 1);
        chk("ovr:done", ndone - db, 0);
        do_read(13'h003, 2'd0, "rd_ovr");

        for (int it = 0; it < 24; it++) begin
            ra = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, 3))
                                              : 13'($urandom_range(0, 'h210));
            if ($urandom_range(0, 1) == 1)
                do_read(ra, 2'($urandom), "rnd_rd");
            else
                do_write(ra, 2'($urandom), $urandom, "rnd_wr");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
